// File: rtl/sdp_wdma_pack_pkg.sv
// Shared SDP definitions for the write-DMA packer: FSM encoding and counter width.
package sdp_wdma_pack_pkg;

    localparam int CNT_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sdp_wdma_pack_if.sv
// Stream bundle for the packer: narrow input beats in, wide masked words out.
interface sdp_wdma_pack_if #(
    parameter int IN_LANES  = 1,
    parameter int OUT_LANES = 8,
    parameter int ELEM_W    = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [IN_LANES*ELEM_W-1:0]  in_pd;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_LANES*ELEM_W-1:0] out_pd;
    logic [OUT_LANES-1:0]        out_mask;
    logic                        out_last;

    modport master (
        output in_valid, in_pd, out_ready,
        input  in_ready, out_valid, out_pd, out_mask, out_last
    );

    modport slave (
        input  in_valid, in_pd, out_ready,
        output in_ready, out_valid, out_pd, out_mask, out_last
    );
endinterface

// File: rtl/sdp_wdma_pack.sv
// Packs IN_LANES-wide beats into OUT_LANES-wide words, one layer per op_en,
// never letting a word straddle a line boundary.
//
// state | meaning
// IDLE  | waiting for reg2dp_op_en
// RUN   | accepting beats and emitting words
// DRAIN | all beats taken, waiting for the last word to leave
module sdp_wdma_pack
    import sdp_wdma_pack_pkg::*;
#(
    parameter int IN_LANES  = 1,
    parameter int OUT_LANES = 8,
    parameter int ELEM_W    = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             reg2dp_op_en,
    input  logic [CNT_W-1:0] reg2dp_line_beats,
    input  logic [CNT_W-1:0] reg2dp_line_num,
    output logic             dp2reg_done,
    sdp_wdma_pack_if.slave   io
);

    localparam int R      = OUT_LANES / IN_LANES;
    localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;
    localparam int IN_W   = IN_LANES * ELEM_W;
    localparam int OUT_W  = OUT_LANES * ELEM_W;

    state_t                r_state;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]      r_line_cnt;
    logic [SLOT_W-1:0]     r_slot;
    logic [OUT_W-1:0]      r_asm;
    logic [OUT_W-1:0]      r_out_pd;
    logic [OUT_LANES-1:0]  r_out_mask;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_line_end;
    logic                  w_layer_end;
    logic                  w_word_end;
    logic [OUT_W-1:0]      w_word;
    logic [OUT_LANES-1:0]  w_mask;

    assign io.in_ready   = (r_state == RUN) && (!r_out_valid || io.out_ready);
    assign w_accept      = io.in_valid && io.in_ready;
    assign w_out_hs      = r_out_valid && io.out_ready;
    assign w_line_end    = (r_beat_cnt == reg2dp_line_beats);
    assign w_layer_end   = w_line_end && (r_line_cnt == reg2dp_line_num);
    assign w_word_end    = (r_slot == SLOT_W'(R - 1)) || w_line_end;

    // The assembly register is kept zero above the current slot, so the
    // emitted word naturally has zeros in its unused lanes.
    always_comb begin
        w_word = r_asm;
        for (int k = 0; k < R; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_word[k*IN_W +: IN_W] = io.in_pd;
            end
        end
        w_mask = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            w_mask[i] = (i < (int'(r_slot) + 1) * IN_LANES);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_line_cnt  <= '0;
            r_slot      <= '0;
            r_asm       <= '0;
            r_out_pd    <= '0;
            r_out_mask  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (reg2dp_op_en) begin
                        r_state    <= RUN;
                        r_beat_cnt <= '0;
                        r_line_cnt <= '0;
                        r_slot     <= '0;
                        r_asm      <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_word_end) begin
                            r_out_pd    <= w_word;
                            r_out_mask  <= w_mask;
                            r_out_last  <= w_layer_end;
                            r_out_valid <= 1'b1;
                            r_asm       <= '0;
                            r_slot      <= '0;
                        end else begin
                            r_asm  <= w_word;
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                        if (w_line_end) begin
                            r_beat_cnt <= '0;
                            r_line_cnt <= r_line_cnt + CNT_W'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                        if (w_layer_end) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_hs && r_out_last) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.out_valid = r_out_valid;
    assign io.out_pd    = r_out_pd;
    assign io.out_mask  = r_out_mask;
    assign io.out_last  = r_out_last;
    assign dp2reg_done  = r_done;

endmodule

// File: tb/tb_sdp_wdma_pack.sv
// Scoreboard bench for sdp_wdma_pack: a 1-lane and a 4-lane instance driven
// with directed and random layers, checked against a line/chunk packing model.
module tb_sdp_wdma_pack;
    import sdp_wdma_pack_pkg::*;

    typedef struct packed {
        logic [63:0] pd;
        logic [7:0]  mask;
        logic        last;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_en_a, op_en_b;
    logic             done_a, done_b;
    logic [CNT_W-1:0] line_beats, line_num;
    int               rdy_mode;
    int               n_cmp = 0;
    int               n_err = 0;
    word_t            exp_a[$];
    word_t            exp_b[$];
    logic [31:0]      stim_q[$];
    bit               prev_last_a, prev_last_b;

    sdp_wdma_pack_if #(.IN_LANES(1), .OUT_LANES(8), .ELEM_W(8)) ifa();
    sdp_wdma_pack_if #(.IN_LANES(4), .OUT_LANES(8), .ELEM_W(8)) ifb();

    sdp_wdma_pack #(.IN_LANES(1), .OUT_LANES(8), .ELEM_W(8)) dut_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en_a),
        .reg2dp_line_beats(line_beats), .reg2dp_line_num(line_num),
        .dp2reg_done(done_a), .io(ifa.slave));

    sdp_wdma_pack #(.IN_LANES(4), .OUT_LANES(8), .ELEM_W(8)) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en_b),
        .reg2dp_line_beats(line_beats), .reg2dp_line_num(line_num),
        .dp2reg_done(done_b), .io(ifb.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each line is cut into chunks of up to R beats; each chunk is one word.
    function automatic void model(input int sel, input int lb, input int ln);
        int          lanes;
        int          r;
        int          idx;
        int          b;
        int          n;
        word_t       w;
        logic [31:0] v;
        lanes = (sel == 0) ? 1 : 4;
        r     = 8 / lanes;
        idx   = 0;
        for (int line = 0; line <= ln; line++) begin
            b = 0;
            while (b <= lb) begin
                w = '0;
                n = ((lb + 1 - b) < r) ? (lb + 1 - b) : r;
                for (int k = 0; k < n; k++) begin
                    v = stim_q[idx];
                    idx++;
                    for (int e = 0; e < lanes; e++) w.pd[(k*lanes+e)*8 +: 8] = v[e*8 +: 8];
                end
                w.mask = 8'((1 << (n * lanes)) - 1);
                w.last = (line == ln) && (b + n > lb);
                if (sel == 0) exp_a.push_back(w);
                else          exp_b.push_back(w);
                b += n;
            end
        end
    endfunction

    task automatic check_word(input int sel, input logic [63:0] pd, input logic [7:0] mask, input logic last);
        word_t e;
        n_cmp++;
        if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_word dut%0d: got pd=%h mask=%h last=%b expected none", sel, pd, mask, last);
            return;
        end
        if (sel == 0) e = exp_a.pop_front();
        else          e = exp_b.pop_front();
        if (pd !== e.pd || mask !== e.mask || last !== e.last) begin
            n_err++;
            $display("FAIL word dut%0d: got pd=%h mask=%h last=%b expected pd=%h mask=%h last=%b",
                     sel, pd, mask, last, e.pd, e.mask, e.last);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_last_a = 1'b0;
        end else begin
            if (prev_last_a) chk("done_a_after_last", {63'd0, done_a}, 64'd1);
            else if (done_a) chk("done_a_unexpected", {63'd0, done_a}, 64'd0);
            if (ifa.out_valid && ifa.out_ready) check_word(0, ifa.out_pd, ifa.out_mask, ifa.out_last);
            prev_last_a = ifa.out_valid && ifa.out_ready && ifa.out_last;
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_last_b = 1'b0;
        end else begin
            if (prev_last_b) chk("done_b_after_last", {63'd0, done_b}, 64'd1);
            else if (done_b) chk("done_b_unexpected", {63'd0, done_b}, 64'd0);
            if (ifb.out_valid && ifb.out_ready) check_word(1, ifb.out_pd, ifb.out_mask, ifb.out_last);
            prev_last_b = ifb.out_valid && ifb.out_ready && ifb.out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                ifa.out_ready = 1'b1;
                ifb.out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                ifa.out_ready = ($urandom_range(99) < 70);
                ifb.out_ready = ($urandom_range(99) < 70);
            end
        end
    end

    task automatic set_in(input int sel, input logic v, input logic [31:0] d);
        if (sel == 0) begin
            ifa.in_valid = v;
            ifa.in_pd    = d[7:0];
        end else begin
            ifb.in_valid = v;
            ifb.in_pd    = d;
        end
    endtask

    task automatic set_op(input int sel, input logic v);
        if (sel == 0) op_en_a = v;
        else          op_en_b = v;
    endtask

    task automatic pulse_op(input int sel);
        @(posedge clk); #1;
        set_op(sel, 1'b1);
        @(posedge clk); #1;
        set_op(sel, 1'b0);
    endtask

    task automatic send_beats(input int sel, input int n, input int gap_pct);
        int budget;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                set_in(sel, 1'b0, '0);
                @(posedge clk); #1;
            end
            set_in(sel, 1'b1, stim_q[i]);
            budget = 0;
            forever begin
                @(negedge clk);
                rdy = (sel == 0) ? ifa.in_ready : ifb.in_ready;
                if (rdy) break;
                budget++;
                if (budget > 300) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_timeout dut%0d: beat %0d not accepted, required acceptance", sel, i);
                    set_in(sel, 1'b0, '0);
                    return;
                end
            end
            @(posedge clk); #1;
        end
        set_in(sel, 1'b0, '0);
    endtask

    task automatic wait_done(input int sel);
        int budget;
        budget = 0;
        forever begin
            @(negedge clk);
            if ((sel == 0 && done_a) || (sel == 1 && done_b)) break;
            budget++;
            if (budget > 1000) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout dut%0d: done not seen, required done", sel);
                break;
            end
        end
        chk("leftover_words", 64'((sel == 0) ? exp_a.size() : exp_b.size()), 64'd0);
    endtask

    task automatic make_stim(input int sel, input int total, input bit incr);
        logic [31:0] v;
        int lanes;
        lanes = (sel == 0) ? 1 : 4;
        stim_q.delete();
        for (int i = 0; i < total; i++) begin
            v = $urandom;
            if (incr) for (int e = 0; e < lanes; e++) v[e*8 +: 8] = 8'(i * lanes + e);
            stim_q.push_back(v);
        end
    endtask

    task automatic run_layer(input int sel, input int lb, input int ln, input bit incr,
                             input int gap_pct, input bit midpulse);
        line_beats = CNT_W'(lb);
        line_num   = CNT_W'(ln);
        make_stim(sel, (lb + 1) * (ln + 1), incr);
        model(sel, lb, ln);
        pulse_op(sel);
        fork
            send_beats(sel, (lb + 1) * (ln + 1), gap_pct);
            if (midpulse) begin
                repeat (4) @(posedge clk);
                #1 set_op(sel, 1'b1);
                @(posedge clk);
                #1 set_op(sel, 1'b0);
            end
        join
        wait_done(sel);
    endtask

    initial begin
        logic [63:0] held;
        int budget;
        rst = 1'b0;
        rdy_mode = 0;
        op_en_a = 1'b0; op_en_b = 1'b0;
        line_beats = '0; line_num = '0;
        ifa.in_valid = 1'b0; ifa.in_pd = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_pd = '0; ifb.out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", {63'd0, ifa.out_valid}, 64'd0);
        chk("rst_a_in_ready",  {63'd0, ifa.in_ready},  64'd0);
        chk("rst_a_out_pd",    ifa.out_pd,             64'd0);
        chk("rst_a_out_mask",  {56'd0, ifa.out_mask},  64'd0);
        chk("rst_a_out_last",  {63'd0, ifa.out_last},  64'd0);
        chk("rst_a_done",      {63'd0, done_a},        64'd0);
        chk("rst_b_out_valid", {63'd0, ifb.out_valid}, 64'd0);
        chk("rst_b_in_ready",  {63'd0, ifb.in_ready},  64'd0);
        chk("rst_b_out_pd",    ifb.out_pd,             64'd0);
        chk("rst_b_out_mask",  {56'd0, ifb.out_mask},  64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Two full words from 0x00..0x0F, then lines with a partial tail word.
        run_layer(0, 15, 0, 1'b1, 0, 1'b0);
        run_layer(0, 9, 1, 1'b0, 0, 1'b0);

        // Output stall on the first word.
        @(posedge clk); #1;
        rdy_mode = 2;
        ifa.out_ready = 1'b0;
        line_beats = CNT_W'(15);
        line_num   = '0;
        make_stim(0, 16, 1'b1);
        model(0, 15, 0);
        pulse_op(0);
        fork
            send_beats(0, 16, 0);
            begin
                budget = 0;
                while (!ifa.out_valid && budget < 100) begin
                    @(negedge clk);
                    budget++;
                end
                held = ifa.out_pd;
                chk("stall_first_word", held, exp_a[0].pd);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {63'd0, ifa.in_ready}, 64'd0);
                    chk("stall_out_pd", ifa.out_pd, held);
                end
                @(posedge clk); #1;
                rdy_mode = 0;
                ifa.out_ready = 1'b1;
            end
        join
        wait_done(0);

        // op_en while running must not disturb the layer.
        run_layer(0, 15, 0, 1'b1, 0, 1'b1);

        // Reset part-way through a layer discards it.
        line_beats = CNT_W'(7);
        line_num   = '0;
        make_stim(0, 8, 1'b1);
        pulse_op(0);
        send_beats(0, 3, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, ifa.in_ready},  64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("postrst_idle_valid", {63'd0, ifa.out_valid}, 64'd0);
        run_layer(0, 7, 0, 1'b1, 0, 1'b0);

        // Four-lane instance: full word then half word.
        run_layer(1, 2, 0, 1'b1, 0, 1'b0);

        // Random layers with input gaps and output backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 5; t++) begin
            run_layer(0, $urandom_range(12), $urandom_range(3), 1'b0, 30, 1'b0);
            run_layer(1, $urandom_range(12), $urandom_range(3), 1'b0, 30, 1'b0);
        end
        rdy_mode = 0;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sdp_wdma_pack.md
SDP_WDMA_PACK -- requirements
Module: sdp_wdma_pack

Interface
REQ-001 SHALL have parameter IN_LANES, default 1, meaning elements per input beat.
REQ-002 SHALL have parameter OUT_LANES, default 8, meaning elements per output word; OUT_LANES is a multiple of IN_LANES; R = OUT_LANES/IN_LANES.
REQ-003 SHALL have parameter ELEM_W, default 8, meaning bits per element.
REQ-004 SHALL have port nvdla_core_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port nvdla_core_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port reg2dp_op_en, input, 1 bit: layer start pulse.
REQ-007 SHALL have port reg2dp_line_beats, input, 13 bits: input beats per line minus 1.
REQ-008 SHALL have port reg2dp_line_num, input, 13 bits: lines per layer minus 1.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_pd (input, IN_LANES*ELEM_W); element 0 is in the LSBs.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_pd (output, OUT_LANES*ELEM_W).
REQ-011 SHALL have port out_mask, output, OUT_LANES bits: one bit per valid element.
REQ-012 SHALL have port out_last, output, 1 bit: final word of the layer.
REQ-013 SHALL have port dp2reg_done, output, 1 bit: one-cycle layer-complete pulse.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN; reg2dp_op_en in IDLE moves to RUN and clears all counters; reg2dp_op_en outside IDLE is ignored.
REQ-015 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready); a beat transfers when in_valid && in_ready.
REQ-016 SHALL write accepted beat k of a word into lanes [k*IN_LANES +: IN_LANES] of an assembly register, using a slot counter 0..R-1.
REQ-017 SHALL load the output register on the beat cycle when the slot count is R-1 or the beat is the last of its line; out_valid rises the next cycle (latency 1).
REQ-018 SHALL set out_mask on a word to the low (slot+1)*IN_LANES bits, leave unused lanes of out_pd zero, and reset the slot to 0 at each line end (a word never spans lines).
REQ-019 SHALL hold out_pd, out_mask and out_last stable while out_valid && !out_ready.
REQ-020 SHALL wrap the beat counter at reg2dp_line_beats and increment the line counter there; the last beat of line reg2dp_line_num sets out_last on its word and moves to DRAIN.
REQ-021 SHALL, in DRAIN, pulse dp2reg_done for one cycle when out_valid && out_ready && out_last and return to IDLE on that cycle.
REQ-022 SHALL permit a word handoff and a new beat acceptance in the same cycle (full throughput when out_ready=1 continuously).
REQ-023 SHALL use no combinational path from in_valid to out_valid.

Reset
REQ-024 SHALL reset asynchronously when nvdla_core_rst=1 to: state IDLE, all counters 0, out_valid=0, out_pd=0, out_mask=0, out_last=0, dp2reg_done=0, in_ready=0.
REQ-025 SHALL discard any partial word on a reset asserted mid-layer, with no output after release until the next reg2dp_op_en.

Structure
REQ-026 SHALL place the state encoding and the counter width (13) in the shared SDP package; IN_LANES, OUT_LANES and ELEM_W remain module parameters.
REQ-027 SHALL be one module with no sub-modules; the counters are inline.

Verification
REQ-028 SHALL cover: defaults, line_beats=15, line_num=0, 16 beats with values 0x00..0x0F and out_ready=1 -> two words 0x0706050403020100 and 0x0F0E0D0C0B0A0908, mask 0xFF, out_last on the second word, done 1 cycle after it.
REQ-029 SHALL cover: line_beats=9, line_num=1 -> per line, a full word then a word with mask 0x03 and upper 6 bytes zero; 4 words in total, out_last only on the 4th.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles at the first word -> in_ready=0 and out_pd stable throughout; no data loss after release.
REQ-031 SHALL cover: IN_LANES=4, OUT_LANES=8, line_beats=2 -> words with mask 0xFF, then 0x0F.
REQ-032 SHALL cover: nvdla_core_rst pulsed after 3 of 8 beats -> out_valid=0 immediately; a subsequent op_en run produces correct words.
REQ-033 SHALL cover: reg2dp_op_en pulsed during RUN -> ignored; counts and done timing unchanged.
